// File: rtl/fc_logits_accum_if.sv
// Stream, weight-memory and logit-vector signals of the output-layer accumulator.
// The slave side is the accumulator; the master side feeds features, weights and bias.
interface fc_logits_accum_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned WT_W   = 8,
  parameter int unsigned IN_LEN = 64,
  parameter int unsigned DIM    = 10
) ();

  localparam int unsigned AddrW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [IN_W-1:0]               in_data;
  logic [AddrW-1:0]              w_addr;
  logic [DIM-1:0][WT_W-1:0]      w_data;
  logic [DIM-1:0][DATA_W-1:0]    bias;
  logic [DIM-1:0][DATA_W-1:0]    logits;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output in_valid,
    output in_data,
    output w_data,
    output bias,
    output out_ready,
    input  in_ready,
    input  w_addr,
    input  logits,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  w_data,
    input  bias,
    input  out_ready,
    output in_ready,
    output w_addr,
    output logits,
    output out_valid
  );

endinterface

// File: rtl/fc_logits_accum.sv
// Output-layer MAC: one signed feature per beat against a weight column, DIM saturating
// accumulators seeded from bias, result held under a valid/ready handshake.
module fc_logits_accum #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned WT_W   = 8,
  parameter int unsigned IN_LEN = 64,
  parameter int unsigned DIM    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  fc_logits_accum_if.slave bus
);

  localparam int unsigned CntW = $clog2(IN_LEN);
  localparam int unsigned PW   = IN_W + WT_W;
  localparam logic [CntW-1:0] LastCnt = CntW'(IN_LEN - 1);

  if (DATA_W < IN_W + WT_W) begin : gen_width_check
    $error("fc_logits_accum: DATA_W must be at least IN_W+WT_W");
  end
  if (IN_LEN < 2) begin : gen_len_check
    $error("fc_logits_accum: IN_LEN must be at least 2");
  end

  typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_first_q, s1_first_d;
  logic [IN_W-1:0]            s1_x_q, s1_x_d;
  logic [DIM-1:0][DATA_W-1:0] acc_q, acc_d;
  logic                       accept;

  // Full-precision signed product, added at DATA_W+1 bits and clamped to the DATA_W range.
  function automatic logic [DATA_W-1:0] mac_sat(input logic [DATA_W-1:0] base,
                                                input logic [IN_W-1:0]   x,
                                                input logic [WT_W-1:0]   w);
    logic [PW-1:0]   x_ext;
    logic [PW-1:0]   w_ext;
    logic [PW-1:0]   prod;
    logic [DATA_W:0] sum;
    x_ext = {{WT_W{x[IN_W-1]}}, x};
    w_ext = {{IN_W{w[WT_W-1]}}, w};
    prod  = x_ext * w_ext;
    sum   = {base[DATA_W-1], base} + {{(DATA_W + 1 - PW){prod[PW-1]}}, prod};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      mac_sat = sum[DATA_W] ? {1'b1, {(DATA_W - 1){1'b0}}} : {1'b0, {(DATA_W - 1){1'b1}}};
    end else begin
      mac_sat = sum[DATA_W-1:0];
    end
  endfunction

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    case (state_q)
      StAccum: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (accept && (cnt_q == LastCnt)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StHold;
      end
      StHold: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = StAccum;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    s1_valid_d = accept;
    s1_first_d = s1_first_q;
    s1_x_d     = s1_x_q;
    acc_d      = acc_q;
    if (accept) begin
      cnt_d      = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
      s1_first_d = (cnt_q == '0);
      s1_x_d     = bus.in_data;
    end
    // w_data already holds the column addressed when this beat was accepted.
    if (s1_valid_q) begin
      for (int j = 0; j < int'(DIM); j++) begin
        acc_d[j] = mac_sat(s1_first_q ? bus.bias[j] : acc_q[j], s1_x_q, bus.w_data[j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAccum;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_x_q     <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_x_q     <= s1_x_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.w_addr = cnt_q;
  assign bus.logits = acc_q;

endmodule

// File: tb/tb_fc_logits_accum.sv
// Bench for fc_logits_accum: directed table of frames, reset and hold sequences, and
// random frames checked against a saturating dot-product model.
module tb_fc_logits_accum;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned WT_W   = 8;
  localparam int unsigned IN_LEN = 4;
  localparam int unsigned DIM    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fc_logits_accum_if #(
    .DATA_W(DATA_W), .IN_W(IN_W), .WT_W(WT_W), .IN_LEN(IN_LEN), .DIM(DIM)
  ) bus ();

  fc_logits_accum #(
    .DATA_W(DATA_W), .IN_W(IN_W), .WT_W(WT_W), .IN_LEN(IN_LEN), .DIM(DIM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int w_mem[IN_LEN][DIM];
  int bias_v[DIM];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Weight memory with one cycle of read latency.
  always @(posedge clk) begin
    for (int j = 0; j < int'(DIM); j++) bus.w_data[j] <= WT_W'(w_mem[bus.w_addr][j]);
  end

  typedef struct {
    logic [IN_LEN-1:0][IN_W-1:0] x;
    int w0;
    int wstep;
    int bstep;
    int e0;
    int estep;
    int mode;
    int hold;
  } row_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_logits(input string name, input int e[DIM]);
    for (int j = 0; j < int'(DIM); j++) begin
      check($sformatf("%s[%0d]", name, j), int'($signed(bus.logits[j])), e[j]);
    end
  endtask

  task automatic apply_bias(input int b[DIM]);
    for (int j = 0; j < int'(DIM); j++) begin
      bias_v[j]   = b[j];
      bus.bias[j] = DATA_W'(b[j]);
    end
  endtask

  function automatic int clamp(input longint v);
    longint lo = -(longint'(1) << (DATA_W - 1));
    longint hi = (longint'(1) << (DATA_W - 1)) - 1;
    if (v < lo) return int'(lo);
    if (v > hi) return int'(hi);
    return int'(v);
  endfunction

  // Each step's sum is clamped, so saturation is sticky only as the arithmetic dictates.
  function automatic void model(input int xs[IN_LEN], output int e[DIM]);
    for (int j = 0; j < int'(DIM); j++) begin
      int a = bias_v[j];
      for (int i = 0; i < int'(IN_LEN); i++) a = clamp(longint'(a) + xs[i] * w_mem[i][j]);
      e[j] = a;
    end
  endfunction

  function automatic int argmax();
    int best = 0;
    for (int j = 1; j < int'(DIM); j++) begin
      if ($signed(bus.logits[j]) > $signed(bus.logits[best])) best = j;
    end
    return best;
  endfunction

  // mode 0: back-to-back, 1: valid pattern 1,0,0,1,0,1,1, 2: random gaps.
  task automatic send_frame(input int xs[IN_LEN], input int n, input int mode,
                            output int first_cyc);
    int k = 0;
    int tries = 0;
    logic v;
    logic [6:0] pat = 7'b1101001;
    first_cyc = -1;
    while (k < n && tries < 100) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = pat[tries % 7];
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = IN_W'(xs[k]);
      if (v && bus.in_ready) begin
        if (first_cyc < 0) first_cyc = cyc_n;
        k++;
      end
      tries++;
    end
    if (k < n) check("frame_accept_timeout", k, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int ov_cyc);
    ov_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) begin
        ov_cyc = cyc_n;
        break;
      end
      @(negedge clk);
    end
    if (ov_cyc < 0) check("out_valid_timeout", 0, 1);
  endtask

  // Holds out_ready low for 'hold' cycles while offering stray beats, then completes.
  task automatic take_out(input int hold, input int e[DIM], input string name);
    check_logits(name, e);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      @(negedge clk);
      check({name, "_hold_out_valid"}, int'(bus.out_valid), 1);
      check({name, "_hold_in_ready"}, int'(bus.in_ready), 0);
      check_logits({name, "_hold"}, e);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, "_done_out_valid"}, int'(bus.out_valid), 0);
    check({name, "_done_in_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    row_t rows[5];
    int xs[IN_LEN];
    int e[DIM];
    int b[DIM];
    int first_cyc, ov_cyc;

    rows[0] = '{x: {8'd4, 8'd3, 8'd2, 8'd1}, w0: 1, wstep: 1, bstep: 0,
                e0: 10, estep: 10, mode: 0, hold: 0};
    rows[1] = '{x: {8'd4, 8'd3, 8'd2, 8'd1}, w0: 1, wstep: 1, bstep: -5,
                e0: 10, estep: 5, mode: 0, hold: 5};
    rows[2] = '{x: {8'h7f, 8'h7f, 8'h7f, 8'h7f}, w0: 127, wstep: 0, bstep: 0,
                e0: 32767, estep: 0, mode: 0, hold: 1};
    rows[3] = '{x: {8'h7f, 8'h7f, 8'h7f, 8'h7f}, w0: -128, wstep: 0, bstep: 0,
                e0: -32768, estep: 0, mode: 0, hold: 0};
    rows[4] = '{x: {8'd4, 8'd3, 8'd2, 8'd1}, w0: 1, wstep: 1, bstep: 0,
                e0: 10, estep: 10, mode: 1, hold: 3};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int j = 0; j < int'(DIM); j++) b[j] = 0;
    apply_bias(b);
    for (int i = 0; i < int'(IN_LEN); i++)
      for (int j = 0; j < int'(DIM); j++) w_mem[i][j] = 0;

    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check_logits("reset_logits", b);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(bus.in_ready), 1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < int'(IN_LEN); i++) begin
        xs[i] = int'($signed(rows[r].x[i]));
        for (int j = 0; j < int'(DIM); j++) w_mem[i][j] = rows[r].w0 + rows[r].wstep * j;
      end
      for (int j = 0; j < int'(DIM); j++) begin
        b[j] = rows[r].bstep * j;
        e[j] = rows[r].e0 + rows[r].estep * j;
      end
      apply_bias(b);
      send_frame(xs, IN_LEN, rows[r].mode, first_cyc);
      wait_out(ov_cyc);
      if (rows[r].mode == 0) begin
        check($sformatf("row%0d_latency", r), ov_cyc - first_cyc, IN_LEN + 1);
      end
      if (r == 0) check("row0_argmax", argmax(), 9);
      take_out(rows[r].hold, e, $sformatf("row%0d", r));
    end

    // Reset after two beats must wipe partial sums; a fresh frame starts clean.
    for (int i = 0; i < int'(IN_LEN); i++) begin
      xs[i] = i + 1;
      for (int j = 0; j < int'(DIM); j++) w_mem[i][j] = j + 1;
    end
    for (int j = 0; j < int'(DIM); j++) b[j] = 0;
    apply_bias(b);
    send_frame(xs, 2, 0, first_cyc);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check_logits("midrst_logits", b);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    for (int j = 0; j < int'(DIM); j++) e[j] = 10 * (j + 1);
    send_frame(xs, IN_LEN, 0, first_cyc);
    wait_out(ov_cyc);
    check("midrst_latency", ov_cyc - first_cyc, IN_LEN + 1);
    take_out(0, e, "midrst_frame");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'(IN_LEN); i++) begin
        xs[i] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < int'(DIM); j++) w_mem[i][j] = int'($urandom_range(0, 255)) - 128;
      end
      for (int j = 0; j < int'(DIM); j++) begin
        b[j] = (r % 2 == 0) ? int'($urandom_range(0, 2000)) - 1000
                            : int'($urandom_range(0, 65535)) - 32768;
      end
      apply_bias(b);
      model(xs, e);
      send_frame(xs, IN_LEN, 2, first_cyc);
      wait_out(ov_cyc);
      take_out(int'($urandom_range(0, 3)), e, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_logits_accum.md
# fc_logits_accum

Output-layer accumulator for the classifier datapath. Accepts one signed feature per cycle over a valid/ready stream and fetches the matching weight column from a 1-cycle-latency weight memory. It multiply-accumulates into DIM saturating logit accumulators and presents the finished logit vector, held under a valid/ready handshake. Its `logits` output connects directly to the combinational argmax stage's `vec` input, with the same DATA_W/DIM.

## Interface
- DATA_W, 32: logit/accumulator/bias width, signed; must be ≥ IN_W+WT_W.
- IN_W, 8: feature width, signed.
- WT_W, 8: weight width, signed.
- IN_LEN, 64: features per frame (≥2).
- DIM, 10: number of logits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  block can accept a feature.
- in_data  in  IN_W  signed feature.
- w_addr  out  $clog2(IN_LEN)  weight column address.
- w_data  in  [DIM] × WT_W  signed weights for column `w_addr` of the previous cycle (1-cycle read latency).
- bias  in  [DIM] × DATA_W  signed per-logit bias; static during a frame.
- logits  out  [DIM] × DATA_W  signed accumulated logits.
- out_valid  out  1  logits complete.
- out_ready  in  1  consumer takes logits.

## Operation
- States: ACCUM, DRAIN, HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready=1; `w_addr` = cnt, driven combinationally.
  - Beat accepted on in_valid&&in_ready; cnt increments; in_data and cnt are registered into stage-1 (s1_valid, s1_x, s1_first = (cnt==0)).
  - Accepting beat IN_LEN-1 moves the FSM to DRAIN and clears cnt to 0.
- Stage-1 MAC (any state, when s1_valid):
  - For each j: p_j = s1_x × w_data[j], full IN_W+WT_W signed, sign-extended to DATA_W.
  - If s1_first: acc[j] ← sat(bias[j] + p_j); else acc[j] ← sat(acc[j] + p_j).
  - sat(): add computed at DATA_W+1 bits, then clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. No wrap, ever.
- DRAIN: in_ready=0; completes the last MAC; next state HOLD.
- HOLD:
  - out_valid=1, in_ready=0; logits = acc, stable.
  - On out_valid&&out_ready, next state is ACCUM.
- logits is driven directly from acc. It is meaningful only while out_valid=1 and changes once the next frame's first MAC lands.
- in_valid while in_ready=0 is ignored; no beat is lost or counted.

## Timing
- Reset (async assert): state=ACCUM, cnt=0, s1_valid=0, acc[*]=0, logits[*]=0, out_valid=0. in_ready=1 from first clock after release. Reset mid-frame discards all partial sums.
- Full throughput: one feature per cycle with in_valid held high. Gaps in in_valid are allowed and only stall.
- w_data for the address presented in cycle t is sampled at the edge ending cycle t+1.
- Last beat accepted in cycle t → MAC in t+1 (DRAIN) → out_valid=1 from cycle t+2. Frame of IN_LEN back-to-back beats: out_valid rises IN_LEN+1 cycles after the first accept.
- out_valid&&out_ready in cycle u → out_valid=0 and in_ready=1 in cycle u+1. No overlap of output handshake and input acceptance.
- out_ready low: HOLD is kept indefinitely and logits are unchanged.
- out_ready high on the first HOLD cycle: out_valid is high for exactly one cycle.

## Test plan
- IN_LEN=4, DATA_W=16, bias=0; x=[1,2,3,4], w_data[j]=j+1 for every column → out_valid 2 cycles after 4th accept, logits=[10,20,…,100]; downstream argmax idx_max=9.
- Same stimulus, bias[j]=−5·j → logits[j]=5·j+10, i.e. [10,15,…,55].
- DATA_W=16, x=127, all w=127, 4 beats → logits all 32767 (saturated, not 64516 wrapped). w=−128 instead → all −32768.
- Frame 1 done, out_ready held low 5 cycles → out_valid=1, in_ready=0, logits constant throughout. Then out_ready=1 → next cycle in_ready=1. Frame 2 result is independent of frame 1.
- in_valid toggled 1,0,0,1,0,1,1 across the frame with the data from the first scenario → identical logits [10…100]. Beats offered while in_ready=0 in HOLD are not consumed.
- rst_n pulsed low after 2 accepted beats → outputs zero immediately. A fresh 4-beat frame gives exactly the first-scenario result.
